shift_ex_stage: RTL and testbench

- Two-stage pipelined shift execution unit for the 16-bit datapath. It sits between the decode/register-read stage and writeback.
- Accepts operand, shift amount, shift opcode and destination tag over a valid/ready handshake. Registers them, computes the shift result and condition flags, and presents a registered result with tag to writeback.
- Supports backpressure and synchronous flush.

---
 rtl/shift_ex_stage.sv | 118 +++++++++++
 tb/tb_shift_ex_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ex_stage.sv
// rtl/shift_ex_stage.sv - two-stage pipelined 16-bit shift/rotate execution unit
module shift_ex_stage #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_d,
    input  logic [3:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_flags
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [SHW-1:0]   s1_d;
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_load;
    logic             s1_adv;

    logic [2*WIDTH-1:0] sll_ext;
    logic [2*WIDTH-1:0] srl_ext;
    logic [2*WIDTH-1:0] rol_ext;
    logic [2*WIDTH-1:0] ror_ext;
    logic [WIDTH-1:0]   res;
    logic               carry;
    logic [3:0]         flags;

    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load;
    assign in_ready = !s1_valid || s2_load;

    // Widened shifts expose the last bit shifted out at a fixed position,
    // and doubling the operand turns rotates into plain shifts.
    always_comb begin
        sll_ext = {{WIDTH{1'b0}}, s1_a} << s1_d;
        srl_ext = {s1_a, {WIDTH{1'b0}}} >> s1_d;
        rol_ext = {s1_a, s1_a} << s1_d;
        ror_ext = {s1_a, s1_a} >> s1_d;
        res     = '0;
        carry   = 1'b0;
        case (s1_op)
            OP_SLL: begin
                res   = sll_ext[WIDTH-1:0];
                carry = sll_ext[WIDTH];
            end
            OP_ROL: begin
                res   = rol_ext[2*WIDTH-1:WIDTH];
                carry = (s1_d != '0) && res[0];
            end
            OP_SRL: begin
                res   = srl_ext[2*WIDTH-1:WIDTH];
                carry = srl_ext[WIDTH-1];
            end
            OP_ROR: begin
                res   = ror_ext[WIDTH-1:0];
                carry = (s1_d != '0) && res[WIDTH-1];
            end
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
        flags = {res[WIDTH-1], (res == '0), carry, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_d      <= '0;
            s1_op     <= '0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                out_valid <= s1_valid;
            end
            if (s1_adv) begin
                out_res   <= res;
                out_tag   <= s1_tag;
                out_flags <= flags;
            end
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a   <= in_a;
                    s1_d   <= in_d;
                    s1_op  <= in_op[1:0];
                    s1_tag <= in_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_ex_stage.sv
// tb/tb_shift_ex_stage.sv - directed and swept checks for shift_ex_stage
module tb_shift_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [3:0]  in_d;
    logic [3:0]  in_op;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [2:0]  out_tag;
    logic [3:0]  out_flags;

    int pass_cnt  = 0;
    int total_cnt = 0;

    shift_ex_stage #(.WIDTH(16), .SHW(4), .TAG_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_d(in_d), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [3:0] d,
                         input logic [3:0] op, input logic [2:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_d     = d;
        in_op    = op;
        in_tag   = tag;
    endtask

    // Bit-by-bit reference: {res, S, Z, C, V}
    function automatic logic [19:0] model(input logic [15:0] a, input int d, input int op);
        logic [15:0] r;
        logic        c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            case (op)
                0: if (i + d < 16) r[i+d] = a[i];
                1: r[(i+d)%16] = a[i];
                2: if (i - d >= 0) r[i-d] = a[i];
                default: r[(i-d+16)%16] = a[i];
            endcase
        end
        if (d != 0) begin
            case (op)
                0: c = a[16-d];
                1: c = r[0];
                2: c = a[d-1];
                default: c = r[15];
            endcase
        end
        return {r, r[15], (r == 16'h0000), c, 1'b0};
    endfunction

    task automatic test_reset;
        logic [23:0] obs;
        rst_n = 1'b0;
        tick();
        tick();
        obs = {out_valid, out_res, out_tag, out_flags};
        total_cnt++;
        if (obs !== 24'h0) $display("FAIL reset_outputs got=%h want=%h", obs, 24'h0);
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_single;
        logic [23:0] obs;
        out_ready = 1'b1;
        drive(16'h8001, 4'd1, 4'b0000, 3'd2);
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL single_latency1 out_valid=%b want 0", out_valid);
        else pass_cnt++;
        tick();
        obs = {out_valid, out_res, out_tag, out_flags};
        total_cnt++;
        if (obs !== {1'b1, 16'h0002, 3'd2, 4'b0010})
            $display("FAIL single_sll got=%h want=%h", obs, {1'b1, 16'h0002, 3'd2, 4'b0010});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] a  [4] = '{16'h8001, 16'h0001, 16'h0001, 16'h1234};
        logic [3:0]  d  [4] = '{4'd4, 4'd1, 4'd1, 4'd0};
        logic [3:0]  op [4] = '{4'b0001, 4'b1111, 4'b0110, 4'b0000};
        logic [2:0]  tg [4] = '{3'd1, 3'd3, 3'd5, 3'd7};
        logic [23:0] ex [4] = '{{1'b1, 16'h0018, 3'd1, 4'b0000},
                                {1'b1, 16'h8000, 3'd3, 4'b1010},
                                {1'b1, 16'h0000, 3'd5, 4'b0110},
                                {1'b1, 16'h1234, 3'd7, 4'b0000}};
        logic [23:0] obs;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(a[i], d[i], op[i], tg[i]);
            else in_valid = 1'b0;
            tick();
            obs = {out_valid, out_res, out_tag, out_flags};
            total_cnt++;
            if (i == 0) begin
                if (out_valid !== 1'b0) $display("FAIL b2b_first out_valid=%b want 0", out_valid);
                else pass_cnt++;
            end else begin
                if (obs !== ex[i-1]) $display("FAIL b2b_op%0d got=%h want=%h", i - 1, obs, ex[i-1]);
                else pass_cnt++;
            end
        end
        tick();
    endtask

    task automatic test_backpressure;
        logic [15:0] a  [4] = '{16'h00FF, 16'h8000, 16'hF000, 16'h000F};
        logic [3:0]  d  [4] = '{4'd4, 4'd15, 4'd4, 4'd4};
        logic [3:0]  op [4] = '{4'b0000, 4'b0010, 4'b0001, 4'b0011};
        logic [2:0]  tg [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [23:0] ex [4] = '{{1'b1, 16'h0FF0, 3'd0, 4'b0000},
                                {1'b1, 16'h0001, 3'd1, 4'b0000},
                                {1'b1, 16'h000F, 3'd2, 4'b0010},
                                {1'b1, 16'hF000, 3'd3, 4'b1010}};
        logic [23:0] obs;
        int next_in  = 0;
        int next_out = 0;
        logic fire_in, fire_out;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c < 3) ? 1'b0 : 1'b1;
            if (next_in < 4) drive(a[next_in], d[next_in], op[next_in], tg[next_in]);
            else in_valid = 1'b0;
            #1;
            obs      = {out_valid, out_res, out_tag, out_flags};
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (c == 2) begin
                total_cnt++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready_drop in_ready=%b want 0", in_ready);
                else pass_cnt++;
            end
            if (c == 2 || c == 3) begin
                total_cnt++;
                if (obs !== ex[0]) $display("FAIL bp_stall_hold c=%0d got=%h want=%h", c, obs, ex[0]);
                else pass_cnt++;
            end
            if (fire_out) begin
                total_cnt++;
                if (next_out >= 4) $display("FAIL bp_extra got=%h want none", obs);
                else if (obs !== ex[next_out])
                    $display("FAIL bp_order idx=%0d got=%h want=%h", next_out, obs, ex[next_out]);
                else pass_cnt++;
                next_out++;
            end
            tick();
            if (fire_in) next_in++;
        end
        total_cnt++;
        if (next_out != 4) $display("FAIL bp_delivered got=%0d want=4", next_out);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        logic [23:0] obs;
        out_ready = 1'b0;
        drive(16'hFFFF, 4'd1, 4'b0000, 3'd4);
        tick();
        drive(16'h1111, 4'd2, 4'b0001, 3'd5);
        tick();
        out_ready = 1'b1;
        flush     = 1'b1;
        drive(16'h2222, 4'd3, 4'b0010, 3'd6);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_clear out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL flush_leak cycle=%0d out_valid=%b want 0", i, out_valid);
            else pass_cnt++;
        end
        drive(16'hFFFF, 4'd8, 4'b0010, 3'd6);
        tick();
        in_valid = 1'b0;
        tick();
        obs = {out_valid, out_res, out_tag, out_flags};
        total_cnt++;
        if (obs !== {1'b1, 16'h00FF, 3'd6, 4'b0010})
            $display("FAIL flush_after got=%h want=%h", obs, {1'b1, 16'h00FF, 3'd6, 4'b0010});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_midop;
        logic [23:0] obs;
        out_ready = 1'b0;
        drive(16'h0F0F, 4'd3, 4'b0000, 3'd1);
        tick();
        drive(16'hF0F0, 4'd5, 4'b0011, 3'd2);
        tick();
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL rst_mid_full in_ready=%b want 0", in_ready);
        else pass_cnt++;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        obs = {out_valid, out_res, out_tag, out_flags};
        total_cnt++;
        if (obs !== 24'h0) $display("FAIL rst_mid_outputs got=%h want=%h", obs, 24'h0);
        else pass_cnt++;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready in_ready=%b want 1", in_ready);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_ghost out_valid=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_sweep;
        logic [15:0] a;
        logic [19:0] m;
        logic [23:0] obs, want;
        out_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            for (int d = 0; d < 16; d++) begin
                for (int k = 0; k < 3; k++) begin
                    a = (k == 0) ? 16'hFFFF : (k == 1) ? 16'h0000 : 16'($urandom);
                    drive(a, 4'(d), {2'($urandom), 2'(op)}, 3'(d + k));
                    tick();
                    in_valid = 1'b0;
                    tick();
                    m    = model(a, d, op);
                    want = {1'b1, m[19:4], 3'(d + k), m[3:0]};
                    obs  = {out_valid, out_res, out_tag, out_flags};
                    total_cnt++;
                    if (obs !== want)
                        $display("FAIL sweep op=%0d d=%0d a=%h got=%h want=%h", op, d, a, obs, want);
                    else pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_d      = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_midop();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
